// File: rtl/serial_ifft_coral_pkg.sv
// fft_pkg: shared types and helpers for the serial inverse-DFT synthesizer.
//   state_t   : frame FSM states (IDLE, RUN)
//   CNT_W     : twiddle-address width for the default frame length
//   sat_round : round-half-up arithmetic shift followed by clamp to x_w bits
package fft_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int FRAME_LENGTH_DEF = 10;
  localparam int CNT_W            = $clog2(FRAME_LENGTH_DEF);

  // Working width of sat_round; wide enough for any realistic product sum.
  localparam int SAT_W = 128;
  localparam logic signed [SAT_W-1:0] SAT_ONE = {{(SAT_W-1){1'b0}}, 1'b1};

  // v is interpreted as an in_w-bit signed value; result fits in x_w bits
  // (sign-extended to SAT_W so callers truncate with a size cast).
  function automatic logic signed [SAT_W-1:0] sat_round(
    input logic signed [SAT_W-1:0] v,
    input int                      in_w,
    input int                      shift,
    input int                      x_w
  );
    logic signed [SAT_W-1:0] t;
    logic signed [SAT_W-1:0] half;
    logic signed [SAT_W-1:0] lim_hi;
    logic signed [SAT_W-1:0] lim_lo;
    t      = v <<< (SAT_W - in_w);
    t      = t >>> (SAT_W - in_w);
    half   = SAT_ONE <<< (shift - 1);
    t      = t + half;
    t      = t >>> shift;
    lim_hi = (SAT_ONE <<< (x_w - 1)) - SAT_ONE;
    lim_lo = -(SAT_ONE <<< (x_w - 1));
    if (t > lim_hi)      sat_round = lim_hi;
    else if (t < lim_lo) sat_round = lim_lo;
    else                 sat_round = t;
  endfunction

endpackage

// File: rtl/serial_ifft_coral_if.sv
// serial_ifft_coral_if: coefficient input handshake, shared twiddle ROM
// address/data, and time-domain output stream of serial_ifft_coral.
//   slave  : seen by the synthesizer (consumes coefficients and ROM data)
//   master : seen by the coefficient source / sample sink / ROM
interface serial_ifft_coral_if #(
  parameter int CHANELS = 2,
  parameter int S_WIDTH = 32,
  parameter int X_WIDTH = 16,
  parameter int W_WIDTH = 16,
  parameter int CNT_W   = 4
);
  logic                              valid_i;
  logic                              ready_o;
  logic [CHANELS-1:0][S_WIDTH-1:0]   re;
  logic [CHANELS-1:0][S_WIDTH-1:0]   im;
  logic [CNT_W-1:0]                  counter;
  logic signed [W_WIDTH-1:0]         w_re;
  logic signed [W_WIDTH-1:0]         w_im;
  logic [CHANELS-1:0][X_WIDTH-1:0]   x;
  logic                              valid_o;
  logic                              last_o;

  modport slave (
    input  valid_i, re, im, w_re, w_im,
    output ready_o, counter, x, valid_o, last_o
  );

  modport master (
    output valid_i, re, im, w_re, w_im,
    input  ready_o, counter, x, valid_o, last_o
  );
endinterface

// File: rtl/serial_ifft_coral_lane.sv
// ifft_lane: one channel of the inverse-DFT synthesizer. Holds the accepted
// coefficient, multiplies it by the conjugate twiddle each cycle and emits
// Re(X * conj(w)) rounded and saturated to X_WIDTH.
//   clk, arst      : clock, asynchronous active-high reset
//   cap_i          : capture re_i/im_i into the holding register
//   re_i, im_i     : coefficient real/imaginary part
//   w_re_i, w_im_i : registered twiddle ROM data (cos, -sin)
//   x_o            : output sample register
module ifft_lane
  import fft_pkg::*;
#(
  parameter int W_WIDTH = 16,
  parameter int X_WIDTH = 16,
  parameter int S_WIDTH = 32,
  parameter int SHIFT   = 15
) (
  input  logic                      clk,
  input  logic                      arst,
  input  logic                      cap_i,
  input  logic signed [S_WIDTH-1:0] re_i,
  input  logic signed [S_WIDTH-1:0] im_i,
  input  logic signed [W_WIDTH-1:0] w_re_i,
  input  logic signed [W_WIDTH-1:0] w_im_i,
  output logic signed [X_WIDTH-1:0] x_o
);

  localparam int PW = S_WIDTH + W_WIDTH;
  localparam int SW = PW + 1;

  logic signed [S_WIDTH-1:0] re_p0_q, re_p0_d, im_p0_q, im_p0_d;
  logic signed [S_WIDTH-1:0] re_p1_q, re_p1_d, im_p1_q, im_p1_d;
  logic signed [PW-1:0]      prod_re_p2_q, prod_re_p2_d;
  logic signed [PW-1:0]      prod_im_p2_q, prod_im_p2_d;
  logic signed [SW-1:0]      sum_p2;
  logic signed [X_WIDTH-1:0] x_p3_q, x_p3_d;

  always_comb begin
    // p0: holding register, overwritten only on accept
    re_p0_d      = cap_i ? re_i : re_p0_q;
    im_p0_d      = cap_i ? im_i : im_p0_q;
    // p1: copy aligned with ROM data, so a new accept cannot disturb the
    // last address of the previous frame still being multiplied
    re_p1_d      = re_p0_q;
    im_p1_d      = im_p0_q;
    // p2: products
    prod_re_p2_d = PW'(re_p1_q) * PW'(w_re_i);
    prod_im_p2_d = PW'(im_p1_q) * PW'(w_im_i);
    // p3: sum, round, saturate
    sum_p2       = SW'(prod_re_p2_q) + SW'(prod_im_p2_q);
    x_p3_d       = X_WIDTH'(sat_round(SAT_W'(sum_p2), SW, SHIFT, X_WIDTH));
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      re_p0_q      <= '0;
      im_p0_q      <= '0;
      re_p1_q      <= '0;
      im_p1_q      <= '0;
      prod_re_p2_q <= '0;
      prod_im_p2_q <= '0;
      x_p3_q       <= '0;
    end else begin
      re_p0_q      <= re_p0_d;
      im_p0_q      <= im_p0_d;
      re_p1_q      <= re_p1_d;
      im_p1_q      <= im_p1_d;
      prod_re_p2_q <= prod_re_p2_d;
      prod_im_p2_q <= prod_im_p2_d;
      x_p3_q       <= x_p3_d;
    end
  end

  assign x_o = x_p3_q;

endmodule

// File: rtl/serial_ifft_coral.sv
// serial_ifft_coral: serial single-bin inverse DFT synthesizer. Accepts one
// complex coefficient per channel and emits FRAME_LENGTH real samples per
// channel, one per clock, using an external registered twiddle ROM pair
// addressed by the sample counter.
//   clk, arst : clock, asynchronous active-high reset
//   bus       : serial_ifft_coral_if.slave
//               valid_i/ready_o/re/im : coefficient handshake
//               counter/w_re/w_im     : twiddle ROM address and data (+1 cycle)
//               x/valid_o/last_o      : output samples, 3 cycles after address
module serial_ifft_coral
  import fft_pkg::*;
#(
  parameter int W_WIDTH      = 16,
  parameter int X_WIDTH      = 16,
  parameter int S_WIDTH      = 32,
  parameter int FRAME_LENGTH = 10,
  parameter int CHANELS      = 2,
  parameter int SHIFT        = 15
) (
  input  logic                clk,
  input  logic                arst,
  serial_ifft_coral_if.slave  bus
);

  localparam int               CTR_W    = $clog2(FRAME_LENGTH);
  localparam logic [CTR_W-1:0] LAST_CNT = CTR_W'(FRAME_LENGTH - 1);

  state_t           state_q;
  logic [CTR_W-1:0] cnt_q;
  logic             ready;
  logic             accept;
  logic             vld_p0, last_p0;
  logic             vld_p1_q, vld_p1_d, last_p1_q, last_p1_d;
  logic             vld_p2_q, vld_p2_d, last_p2_q, last_p2_d;
  logic             vld_p3_q, vld_p3_d, last_p3_q, last_p3_d;
  logic signed [X_WIDTH-1:0] x_lane [CHANELS];

  // Ready in the last address cycle as well, so frames can abut.
  assign ready  = (state_q == IDLE) || (state_q == RUN && cnt_q == LAST_CNT);
  assign accept = bus.valid_i && ready;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (accept) state_q <= RUN;
        end
        RUN: begin
          if (cnt_q == LAST_CNT) begin
            cnt_q <= '0;
            if (!accept) state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CTR_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    // p0: address cycle
    vld_p0    = (state_q == RUN);
    last_p0   = vld_p0 && (cnt_q == LAST_CNT);
    // p1: ROM data
    vld_p1_d  = vld_p0;
    last_p1_d = last_p0;
    // p2: products
    vld_p2_d  = vld_p1_q;
    last_p2_d = last_p1_q;
    // p3: output sample
    vld_p3_d  = vld_p2_q;
    last_p3_d = last_p2_q;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      vld_p1_q  <= 1'b0;
      last_p1_q <= 1'b0;
      vld_p2_q  <= 1'b0;
      last_p2_q <= 1'b0;
      vld_p3_q  <= 1'b0;
      last_p3_q <= 1'b0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      last_p1_q <= last_p1_d;
      vld_p2_q  <= vld_p2_d;
      last_p2_q <= last_p2_d;
      vld_p3_q  <= vld_p3_d;
      last_p3_q <= last_p3_d;
    end
  end

  for (genvar c = 0; c < CHANELS; c++) begin : g_lane
    ifft_lane #(
      .W_WIDTH (W_WIDTH),
      .X_WIDTH (X_WIDTH),
      .S_WIDTH (S_WIDTH),
      .SHIFT   (SHIFT)
    ) u_lane (
      .clk    (clk),
      .arst   (arst),
      .cap_i  (accept),
      .re_i   (bus.re[c]),
      .im_i   (bus.im[c]),
      .w_re_i (bus.w_re),
      .w_im_i (bus.w_im),
      .x_o    (x_lane[c])
    );
  end

  always_comb begin
    bus.x = '0;
    for (int c = 0; c < CHANELS; c++) bus.x[c] = x_lane[c];
  end

  assign bus.ready_o = ready;
  assign bus.counter = cnt_q;
  assign bus.valid_o = vld_p3_q;
  assign bus.last_o  = last_p3_q;

endmodule

// File: tb/tb_serial_ifft_coral.sv
// Bench for serial_ifft_coral with N=4. Two instances share stimulus and the
// twiddle ROM: u_a with SHIFT=15 and u_b with SHIFT=1.
module tb_serial_ifft_coral;

  localparam int N = 4;

  logic clk = 1'b0;
  logic arst = 1'b1;
  int unsigned cyc = 0;

  serial_ifft_coral_if #(.CHANELS(2), .S_WIDTH(32), .X_WIDTH(16), .W_WIDTH(16), .CNT_W(2)) ifa ();
  serial_ifft_coral_if #(.CHANELS(2), .S_WIDTH(32), .X_WIDTH(16), .W_WIDTH(16), .CNT_W(2)) ifb ();

  serial_ifft_coral #(.W_WIDTH(16), .X_WIDTH(16), .S_WIDTH(32), .FRAME_LENGTH(N),
                      .CHANELS(2), .SHIFT(15)) u_a (.clk(clk), .arst(arst), .bus(ifa));
  serial_ifft_coral #(.W_WIDTH(16), .X_WIDTH(16), .S_WIDTH(32), .FRAME_LENGTH(N),
                      .CHANELS(2), .SHIFT(1))  u_b (.clk(clk), .arst(arst), .bus(ifb));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered twiddle ROM, addressed by the SHIFT=15 instance.
  logic signed [15:0] rom_re [4];
  logic signed [15:0] rom_im [4];
  logic signed [15:0] w_re_q = '0, w_im_q = '0;
  always @(posedge clk) begin
    w_re_q <= rom_re[ifa.counter];
    w_im_q <= rom_im[ifa.counter];
  end
  assign ifa.w_re = w_re_q;
  assign ifa.w_im = w_im_q;
  assign ifb.w_re = w_re_q;
  assign ifb.w_im = w_im_q;
  assign ifb.valid_i = ifa.valid_i;
  assign ifb.re = ifa.re;
  assign ifb.im = ifa.im;

  typedef struct {
    logic signed [31:0] re0, im0, re1, im1;
    int xa0[4];
    int xa1[4];
    int xb0[4];
  } vec_t;

  typedef struct {
    int unsigned cyc;
    longint xa0, xa1, xb0, xb1;
    bit last;
  } exp_t;

  exp_t q[$];
  vec_t tab[4];
  int n_cmp = 0, n_err = 0;
  bit have = 0, ready_exp = 1, last_acc = 0, use_const = 0;
  int unsigned acc_e = 0;
  int nx_a0[4], nx_a1[4], nx_b0[4];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Re(X * conj(w)) for sample n, rounded half-up at `sh` and clamped to 16 bits.
  function automatic longint ref_x(input longint r, input longint i, input int n, input int sh);
    longint s;
    s = r * longint'(rom_re[n]) + i * longint'(rom_im[n]);
    s = s + (longint'(1) <<< (sh - 1));
    s = s >>> sh;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  function automatic logic signed [31:0] rnd_coef();
    case ($urandom_range(0, 2))
      0:       return 32'($urandom_range(0, 65535)) - 32'sd32768;
      1:       return 32'($urandom_range(0, 8388607)) - 32'sd4194304;
      default: return 32'($urandom);
    endcase
  endfunction

  // Outputs at this negedge against the model's frame timeline.
  task automatic check_outputs();
    int unsigned c;
    bit act;
    int cnt_exp;
    c = cyc;
    act = have && (c < acc_e + N);
    cnt_exp = act ? int'(c - acc_e) : 0;
    ready_exp = !act || (cnt_exp == N - 1);
    chk("ready_o", longint'(ifa.ready_o), longint'(ready_exp));
    chk("counter", longint'(ifa.counter), longint'(cnt_exp));
    if (q.size() > 0 && q[0].cyc == c) begin
      chk("valid_o", longint'(ifa.valid_o), 1);
      chk("last_o", longint'(ifa.last_o), longint'(q[0].last));
      chk("x0", longint'($signed(ifa.x[0])), q[0].xa0);
      chk("x1", longint'($signed(ifa.x[1])), q[0].xa1);
      chk("b_valid_o", longint'(ifb.valid_o), 1);
      chk("b_x0", longint'($signed(ifb.x[0])), q[0].xb0);
      chk("b_x1", longint'($signed(ifb.x[1])), q[0].xb1);
      void'(q.pop_front());
    end else begin
      chk("valid_o_idle", longint'(ifa.valid_o), 0);
      chk("last_o_idle", longint'(ifa.last_o), 0);
      chk("b_valid_o_idle", longint'(ifb.valid_o), 0);
    end
  endtask

  task automatic push_frame(input logic signed [31:0] r0, i0, r1, i1);
    exp_t e;
    for (int n = 0; n < N; n++) begin
      e.cyc  = cyc + 1 + 3 + n;
      e.xa0  = use_const ? longint'(nx_a0[n]) : ref_x(r0, i0, n, 15);
      e.xa1  = use_const ? longint'(nx_a1[n]) : ref_x(r1, i1, n, 15);
      e.xb0  = use_const ? longint'(nx_b0[n]) : ref_x(r0, i0, n, 1);
      e.xb1  = ref_x(r1, i1, n, 1);
      e.last = (n == N - 1);
      q.push_back(e);
    end
  endtask

  task automatic step(input bit v, input logic signed [31:0] r0, i0, r1, i1);
    @(negedge clk);
    check_outputs();
    ifa.valid_i = v;
    ifa.re[0] = r0; ifa.im[0] = i0;
    ifa.re[1] = r1; ifa.im[1] = i1;
    last_acc = 0;
    if (v && ready_exp && !arst) begin
      push_frame(r0, i0, r1, i1);
      have = 1;
      acc_e = cyc + 1;
      last_acc = 1;
    end
  endtask

  task automatic idle(input int k);
    repeat (k) step(0, rnd_coef(), rnd_coef(), rnd_coef(), rnd_coef());
  endtask

  task automatic offer(input logic signed [31:0] r0, i0, r1, i1);
    last_acc = 0;
    for (int k = 0; k < 20 && !last_acc; k++) step(1, r0, i0, r1, i1);
    chk("offer_accepted", longint'(last_acc), 1);
  endtask

  task automatic drain();
    idle(N + 5);
    chk("drained", longint'(q.size()), 0);
  endtask

  task automatic use_row(input int r);
    use_const = 1;
    nx_a0 = tab[r].xa0; nx_a1 = tab[r].xa1; nx_b0 = tab[r].xb0;
  endtask

  initial begin
    rom_re = '{16'sd32767, 16'sd0, 16'h8000, 16'sd0};
    rom_im = '{16'sd0, 16'h8000, 16'sd0, 16'sd32767};
    ifa.valid_i = 0; ifa.re = '0; ifa.im = '0;

    tab[0].re0 = 1000; tab[0].im0 = 0; tab[0].re1 = 0; tab[0].im1 = 2000;
    tab[0].xa0 = '{1000, 0, -1000, 0};      tab[0].xa1 = '{0, -2000, 0, 2000};
    tab[0].xb0 = '{32767, 0, -32768, 0};
    tab[1].re0 = 1 << 20; tab[1].im0 = 0; tab[1].re1 = -(1 << 20); tab[1].im1 = 0;
    tab[1].xa0 = '{32767, 0, -32768, 0};    tab[1].xa1 = '{-32768, 0, 32767, 0};
    tab[1].xb0 = '{32767, 0, -32768, 0};
    tab[2].re0 = 1; tab[2].im0 = 0; tab[2].re1 = 0; tab[2].im1 = 0;
    tab[2].xa0 = '{1, 0, -1, 0};            tab[2].xa1 = '{0, 0, 0, 0};
    tab[2].xb0 = '{16384, 0, -16384, 0};
    tab[3].re0 = 300; tab[3].im0 = -400; tab[3].re1 = -12345; tab[3].im1 = 6789;
    tab[3].xa0 = '{300, 400, -300, -400};   tab[3].xa1 = '{-12345, -6789, 12345, 6789};
    tab[3].xb0 = '{32767, 32767, -32768, -32768};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready_o", longint'(ifa.ready_o), 1);
    chk("rst_counter", longint'(ifa.counter), 0);
    chk("rst_valid_o", longint'(ifa.valid_o), 0);
    chk("rst_last_o", longint'(ifa.last_o), 0);
    chk("rst_x0", longint'($signed(ifa.x[0])), 0);
    chk("rst_x1", longint'($signed(ifa.x[1])), 0);
    arst = 0;
    idle(2);

    // Directed single frames from the table
    for (int r = 0; r < 4; r++) begin
      use_row(r);
      offer(tab[r].re0, tab[r].im0, tab[r].re1, tab[r].im1);
      drain();
    end

    // Back-to-back: second coefficient held valid until counter==N-1
    use_row(0);
    offer(tab[0].re0, tab[0].im0, tab[0].re1, tab[0].im1);
    nx_a0 = '{500, 0, -500, 0}; nx_a1 = '{0, 0, 0, 0}; nx_b0 = '{32767, 0, -32768, 0};
    offer(500, 0, 0, 0);
    drain();

    // Not ready: valid_i pulsed at counter==1 must not be captured
    use_row(0);
    offer(tab[0].re0, tab[0].im0, tab[0].re1, tab[0].im1);
    idle(1);
    step(1, 777, 777, 777, 777);
    drain();

    // Reset mid-frame (second of two abutting frames at counter==2)
    use_row(0);
    offer(tab[0].re0, tab[0].im0, tab[0].re1, tab[0].im1);
    nx_a0 = '{500, 0, -500, 0}; nx_a1 = '{0, 0, 0, 0}; nx_b0 = '{32767, 0, -32768, 0};
    offer(500, 0, 0, 0);
    idle(2);
    @(negedge clk);
    check_outputs();
    arst = 1;
    #1;
    chk("mid_rst_valid_o", longint'(ifa.valid_o), 0);
    chk("mid_rst_last_o", longint'(ifa.last_o), 0);
    chk("mid_rst_x0", longint'($signed(ifa.x[0])), 0);
    chk("mid_rst_x1", longint'($signed(ifa.x[1])), 0);
    chk("mid_rst_counter", longint'(ifa.counter), 0);
    q.delete();
    have = 0;
    step(1, 777, 0, 777, 0);
    step(0, 0, 0, 0, 0);
    arst = 0;
    idle(6);
    use_row(0);
    offer(tab[0].re0, tab[0].im0, tab[0].re1, tab[0].im1);
    drain();

    // Randomized frames with random gaps (gap 0 gives abutting frames)
    for (int n = 0; n < 4; n++) begin
      rom_re[n] = 16'($urandom);
      rom_im[n] = 16'($urandom);
    end
    idle(3);
    use_const = 0;
    for (int f = 0; f < 40; f++) begin
      idle($urandom_range(0, 3));
      offer(rnd_coef(), rnd_coef(), rnd_coef(), rnd_coef());
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
